fpu_addsub_pipe: RTL and testbench

Parametrised, fully pipelined IEEE-754 binary floating-point adder/subtractor with a per-transaction operation select. It accepts one operand pair per cycle and returns the rounded result a fixed three cycles later. It is the next-generation add/sub datapath for the FPU and replaces separate fixed-width add and sub units. Widths are generic, so one block serves single precision (default) and other exponent/mantissa splits.

---
 rtl/fpu_pkg.sv | 42 ++++
 rtl/fpu_lzc.sv | 17 +
 rtl/fpu_addsub_pipe.sv | 224 ++++++++++++++++++++++
 tb/tb_fpu_addsub_pipe.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: width limits, unpacked operand, special-value constants, flag indices.
package fpu_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;
    localparam int MAX_EXP_W = 16;
    localparam int MAX_MAN_W = 64;
    localparam int MAX_W     = 1 + MAX_EXP_W + MAX_MAN_W;

    localparam int FLG_INVALID   = 3;
    localparam int FLG_OVERFLOW  = 2;
    localparam int FLG_UNDERFLOW = 1;
    localparam int FLG_INEXACT   = 0;

    // Fields sized for the widest supported format; users take the low EXP_W / MAN_W+1 bits.
    typedef struct packed {
        logic                 sign;
        logic [MAX_EXP_W-1:0] exp;
        logic [MAX_MAN_W:0]   mant;
        logic                 is_nan;
        logic                 is_snan;
        logic                 is_inf;
        logic                 is_zero;
    } fp_unpk_t;

    function automatic logic [MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < exp_w; i++) r[man_w + i] = 1'b1;
        r[man_w - 1] = 1'b1;
        return r;
    endfunction

    function automatic logic [MAX_W-1:0] fp_inf(input logic sign, input int exp_w, input int man_w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < exp_w; i++) r[man_w + i] = 1'b1;
        r[exp_w + man_w] = sign;
        return r;
    endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; an all-zero input returns W.
module fpu_lzc #(
    parameter int  W  = 28,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  din,
    output logic [CW-1:0] cnt
);

    // Higher set bits overwrite lower ones, so the most significant one wins.
    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++)
            if (din[i]) cnt = CW'(W - 1 - i);
    end

endmodule

// File: rtl/fpu_addsub_pipe.sv
// Three-stage IEEE-754 add/sub (RNE, denormals flushed to zero).
// FPU_ADDSUB_FLAGS_EN adds the {invalid, overflow, underflow, inexact} flags port and its pipeline.
module fpu_addsub_pipe
    import fpu_pkg::*;
#(
    parameter int  EXP_W = EXP_W_DEF,
    parameter int  MAN_W = MAN_W_DEF,
    localparam int nBITS = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [nBITS-1:0] din1,
    input  logic [nBITS-1:0] din2,
    input  logic             op,
    input  logic             dval,
    output logic [nBITS-1:0] result,
    output logic             rdy
`ifdef FPU_ADDSUB_FLAGS_EN
    ,
    output logic [3:0]       flags
`endif
);

    localparam int STAGES = 3;
    localparam int MW     = MAN_W + 4;
    localparam int SW     = MAN_W + 5;
    localparam int CW     = $clog2(SW + 1);
    localparam int XW     = ((EXP_W > CW) ? EXP_W : CW) + 2;

    localparam logic [nBITS-1:0] QNAN = nBITS'(fp_qnan(EXP_W, MAN_W));
    localparam logic [nBITS-1:0] PINF = nBITS'(fp_inf(1'b0, EXP_W, MAN_W));
    localparam logic [nBITS-1:0] NINF = nBITS'(fp_inf(1'b1, EXP_W, MAN_W));
    localparam logic [XW-1:0]    EMAX = XW'((1 << EXP_W) - 1);

    function automatic fp_unpk_t unpack(input logic [nBITS-1:0] w, input logic s);
        fp_unpk_t         u;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] f;
        e = w[nBITS-2:MAN_W];
        f = w[MAN_W-1:0];
        u = '0;
        u.sign    = s;
        u.is_zero = (e == '0);
        u.is_inf  = (&e) && (f == '0);
        u.is_nan  = (&e) && (f != '0);
        u.is_snan = u.is_nan && !f[MAN_W-1];
        if (!u.is_zero) begin
            u.exp  = MAX_EXP_W'(e);
            u.mant = (MAX_MAN_W + 1)'({1'b1, f});
        end
        return u;
    endfunction

    logic [STAGES:1] vld_pipe;

    // ---------------- stage 1: unpack / order / align ----------------
    fp_unpk_t         ua, ub;
    logic [EXP_W-1:0] ea, eb, e_big, e_small, d;
    logic [MAN_W:0]   ma, mb, m_big, m_small;
    logic             a_big, s_big, sp_n, inv_n;
    logic [MW-1:0]    sm_ext, mask, aligned;
    logic [nBITS-1:0] sp_res_n;

    always_comb begin
        ua      = unpack(din1, din1[nBITS-1]);
        ub      = unpack(din2, din2[nBITS-1] ^ op);
        ea      = ua.exp[EXP_W-1:0];
        eb      = ub.exp[EXP_W-1:0];
        ma      = ua.mant[MAN_W:0];
        mb      = ub.mant[MAN_W:0];
        a_big   = {ea, ma} >= {eb, mb};
        e_big   = a_big ? ea : eb;
        e_small = a_big ? eb : ea;
        m_big   = a_big ? ma : mb;
        m_small = a_big ? mb : ma;
        s_big   = a_big ? ua.sign : ub.sign;
        d       = e_big - e_small;
        sm_ext  = {m_small, 3'b000};
        mask    = ~({MW{1'b1}} << d);
        if (int'(d) >= MAN_W + 3)
            aligned = {{(MW-1){1'b0}}, |m_small};
        else
            aligned = (sm_ext >> d) | {{(MW-1){1'b0}}, |(sm_ext & mask)};

        sp_n     = ua.is_nan | ub.is_nan | ua.is_inf | ub.is_inf;
        inv_n    = 1'b0;
        sp_res_n = QNAN;
        if (ua.is_nan || ub.is_nan)
            inv_n = ua.is_snan | ub.is_snan;
        else if (ua.is_inf && ub.is_inf) begin
            if (ua.sign != ub.sign) inv_n = 1'b1;
            else sp_res_n = ua.sign ? NINF : PINF;
        end else if (ua.is_inf)
            sp_res_n = ua.sign ? NINF : PINF;
        else
            sp_res_n = ub.sign ? NINF : PINF;
    end

    logic             s1_sp, s1_sign, s1_zsign, s1_sub;
    logic [nBITS-1:0] s1_sp_res;
    logic [EXP_W-1:0] s1_exp;
    logic [MW-1:0]    s1_mbig, s1_msml;

    always_ff @(posedge clk) begin
        if (rst_n && dval) begin
            s1_sp     <= sp_n;
            s1_sp_res <= sp_res_n;
            s1_sign   <= s_big;
            s1_zsign  <= ua.sign & ub.sign;
            s1_sub    <= ua.sign ^ ub.sign;
            s1_exp    <= e_big;
            s1_mbig   <= {m_big, 3'b000};
            s1_msml   <= aligned;
        end
    end

    // ---------------- stage 2: add / LZC ----------------
    logic [SW-1:0] sum_n;
    logic [CW-1:0] lz_n;

    assign sum_n = s1_sub ? ({1'b0, s1_mbig} - {1'b0, s1_msml})
                          : ({1'b0, s1_mbig} + {1'b0, s1_msml});

    fpu_lzc #(.W(SW)) u_lzc (
        .din (sum_n),
        .cnt (lz_n)
    );

    logic             s2_sp, s2_sign, s2_zsign;
    logic [nBITS-1:0] s2_sp_res;
    logic [EXP_W-1:0] s2_exp;
    logic [SW-1:0]    s2_sum;
    logic [CW-1:0]    s2_lz;

    always_ff @(posedge clk) begin
        if (vld_pipe[1]) begin
            s2_sp     <= s1_sp;
            s2_sp_res <= s1_sp_res;
            s2_sign   <= s1_sign;
            s2_zsign  <= s1_zsign;
            s2_exp    <= s1_exp;
            s2_sum    <= sum_n;
            s2_lz     <= lz_n;
        end
    end

    // ---------------- stage 3: normalise / round / pack ----------------
    logic [CW-1:0]    sh;
    logic [MW-1:0]    norm;
    logic [XW-1:0]    e_n, e_r;
    logic             rup, zero, ovf, unf;
    logic [MAN_W+1:0] mr;
    logic [MAN_W-1:0] frac;
    logic [nBITS-1:0] res_n;

    always_comb begin
        sh = s2_lz - CW'(1);
        // Hidden bit belongs at MW-1: carry shifts right once, otherwise left by lz-1.
        if (s2_sum[SW-1]) begin
            norm = s2_sum[SW-1:1] | {{(MW-1){1'b0}}, s2_sum[0]};
            e_n  = {{(XW-EXP_W){1'b0}}, s2_exp} + XW'(1);
        end else begin
            norm = s2_sum[MW-1:0] << sh;
            e_n  = {{(XW-EXP_W){1'b0}}, s2_exp} - XW'(sh);
        end
        rup  = norm[2] & (norm[1] | norm[0] | norm[3]);
        mr   = {1'b0, norm[MW-1:3]} + (MAN_W + 2)'(rup);
        e_r  = e_n + XW'(mr[MAN_W+1]);
        frac = mr[MAN_W+1] ? '0 : mr[MAN_W-1:0];
        zero = (s2_sum == '0);
        ovf  = !e_r[XW-1] && (e_r >= EMAX);
        unf  = e_r[XW-1] || (e_r == '0);

        res_n = {s2_sign, e_r[EXP_W-1:0], frac};
        if (s2_sp)     res_n = s2_sp_res;
        else if (zero) res_n = {s2_zsign, {(nBITS-1){1'b0}}};
        else if (ovf)  res_n = s2_sign ? NINF : PINF;
        else if (unf)  res_n = {s2_sign, {(nBITS-1){1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            result   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], dval};
            if (vld_pipe[2]) result <= res_n;
        end
    end

    assign rdy = vld_pipe[STAGES];

`ifdef FPU_ADDSUB_FLAGS_EN
    logic       s1_inv, s2_inv;
    logic [3:0] flags_n;

    always_ff @(posedge clk) begin
        if (rst_n && dval) s1_inv <= inv_n;
        if (vld_pipe[1])   s2_inv <= s1_inv;
    end

    always_comb begin
        flags_n = '0;
        if (s2_sp)
            flags_n[FLG_INVALID] = s2_inv;
        else if (!zero) begin
            if (ovf) begin
                flags_n[FLG_OVERFLOW] = 1'b1;
                flags_n[FLG_INEXACT]  = 1'b1;
            end else if (unf) begin
                flags_n[FLG_UNDERFLOW] = 1'b1;
                flags_n[FLG_INEXACT]   = 1'b1;
            end else
                flags_n[FLG_INEXACT] = |norm[2:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)           flags <= '0;
        else if (vld_pipe[2]) flags <= flags_n;
    end
`endif

endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// Directed bench for fpu_addsub_pipe at single precision.
module tb_fpu_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] din1 = '0, din2 = '0;
    logic        op = 1'b0, dval = 1'b0;
    logic [31:0] result;
    logic        rdy;
`ifdef FPU_ADDSUB_FLAGS_EN
    logic [3:0]  flags;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fpu_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .din1   (din1),
        .din2   (din2),
        .op     (op),
        .dval   (dval),
        .result (result),
        .rdy    (rdy)
`ifdef FPU_ADDSUB_FLAGS_EN
        ,
        .flags  (flags)
`endif
    );

    // Issues one operation and reports what came out three cycles later.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic o,
                         output logic [31:0] res, output logic early, output logic got,
                         output logic [3:0] fl);
        @(posedge clk); #1;
        din1 = a; din2 = b; op = o; dval = 1'b1;
        @(posedge clk); #1;
        dval = 1'b0;
        @(negedge clk); early = rdy;
        @(posedge clk);
        @(negedge clk); early = early | rdy;
        @(posedge clk);
        @(negedge clk);
        got = rdy;
        res = result;
`ifdef FPU_ADDSUB_FLAGS_EN
        fl = flags;
`else
        fl = 4'h0;
`endif
    endtask

    task automatic test_reset();
        logic seen;
        rst_n = 1'b0;
        din1 = 32'h3F800000; din2 = 32'h40000000; op = 1'b0; dval = 1'b1;
        repeat (3) @(posedge clk);
        #1 dval = 1'b0;
        @(negedge clk);
        total++; if (rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy: got %b want 0", rdy); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 00000000", result); end
`ifdef FPU_ADDSUB_FLAGS_EN
        total++; if (flags !== 4'h0) begin bad++; $display("FAIL reset_flags: got %b want 0000", flags); end
`endif
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (5) begin @(negedge clk); seen = seen | rdy; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL reset_dval_ignored: got rdy %b want 0", seen); end
    endtask

    task automatic test_basic();
        logic [31:0] va[4], vb[4], ve[4];
        logic        vo[4];
        logic [31:0] res;
        logic        early, got;
        logic [3:0]  fl;
        va[0] = 32'h3F800000; vb[0] = 32'h40000000; vo[0] = 1'b0; ve[0] = 32'h40400000;
        va[1] = 32'h40400000; vb[1] = 32'h3F800000; vo[1] = 1'b1; ve[1] = 32'h40000000;
        va[2] = 32'h3F800000; vb[2] = 32'h3F800000; vo[2] = 1'b1; ve[2] = 32'h00000000;
        va[3] = 32'h80000000; vb[3] = 32'h80000000; vo[3] = 1'b0; ve[3] = 32'h80000000;
        for (int i = 0; i < 4; i++) begin
            issue(va[i], vb[i], vo[i], res, early, got, fl);
            total++; if (early !== 1'b0) begin bad++; $display("FAIL basic%0d_early_rdy: got %b want 0", i, early); end
            total++; if (got !== 1'b1) begin bad++; $display("FAIL basic%0d_rdy_lat3: got %b want 1", i, got); end
            total++; if (res !== ve[i]) begin bad++; $display("FAIL basic%0d_result: got %h want %h", i, res, ve[i]); end
`ifdef FPU_ADDSUB_FLAGS_EN
            total++; if (fl !== 4'b0000) begin bad++; $display("FAIL basic%0d_flags: got %b want 0000", i, fl); end
`endif
        end
    endtask

    task automatic test_round();
        logic [31:0] res;
        logic        early, got;
        logic [3:0]  fl;
        issue(32'h3F800000, 32'h33800000, 1'b0, res, early, got, fl);
        total++; if (res !== 32'h3F800000) begin bad++; $display("FAIL round_tie_even: got %h want 3F800000", res); end
`ifdef FPU_ADDSUB_FLAGS_EN
        total++; if (fl !== 4'b0001) begin bad++; $display("FAIL round_tie_flags: got %b want 0001", fl); end
`endif
        issue(32'h3F800000, 32'h33800001, 1'b0, res, early, got, fl);
        total++; if (res !== 32'h3F800001) begin bad++; $display("FAIL round_up: got %h want 3F800001", res); end
    endtask

    task automatic test_special();
        logic [31:0] va[6], vb[6], ve[6];
        logic        vo[6];
        logic [3:0]  vf[6];
        logic [31:0] res;
        logic        early, got;
        logic [3:0]  fl;
        va[0] = 32'h7F800000; vb[0] = 32'h7F800000; vo[0] = 1'b1; ve[0] = 32'h7FC00000; vf[0] = 4'b1000;
        va[1] = 32'h7F7FFFFF; vb[1] = 32'h7F7FFFFF; vo[1] = 1'b0; ve[1] = 32'h7F800000; vf[1] = 4'b0101;
        va[2] = 32'h00800000; vb[2] = 32'h00000001; vo[2] = 1'b1; ve[2] = 32'h00800000; vf[2] = 4'b0000;
        va[3] = 32'h7F800001; vb[3] = 32'h3F800000; vo[3] = 1'b0; ve[3] = 32'h7FC00000; vf[3] = 4'b1000;
        va[4] = 32'hFFC12345; vb[4] = 32'h3F800000; vo[4] = 1'b0; ve[4] = 32'h7FC00000; vf[4] = 4'b0000;
        va[5] = 32'hFF800000; vb[5] = 32'h3F800000; vo[5] = 1'b0; ve[5] = 32'hFF800000; vf[5] = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            issue(va[i], vb[i], vo[i], res, early, got, fl);
            total++; if (res !== ve[i]) begin bad++; $display("FAIL special%0d_result: got %h want %h", i, res, ve[i]); end
`ifdef FPU_ADDSUB_FLAGS_EN
            total++; if (fl !== vf[i]) begin bad++; $display("FAIL special%0d_flags: got %b want %b", i, fl, vf[i]); end
`else
            if (vf[i] == 4'hF) $display("unexpected flag vector %0d", i);
`endif
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va[8], vb[8], ve[8];
        logic        vo[8];
        va[0] = 32'h3F800000; vb[0] = 32'h40000000; vo[0] = 1'b0; ve[0] = 32'h40400000;
        va[1] = 32'h40400000; vb[1] = 32'h3F800000; vo[1] = 1'b1; ve[1] = 32'h40000000;
        va[2] = 32'h40000000; vb[2] = 32'h40000000; vo[2] = 1'b0; ve[2] = 32'h40800000;
        va[3] = 32'h40800000; vb[3] = 32'h40000000; vo[3] = 1'b1; ve[3] = 32'h40000000;
        va[4] = 32'h3F800000; vb[4] = 32'h40000000; vo[4] = 1'b1; ve[4] = 32'hBF800000;
        va[5] = 32'hC0000000; vb[5] = 32'h3F800000; vo[5] = 1'b0; ve[5] = 32'hBF800000;
        va[6] = 32'h3F000000; vb[6] = 32'hBF000000; vo[6] = 1'b1; ve[6] = 32'h3F800000;
        va[7] = 32'h41200000; vb[7] = 32'h40A00000; vo[7] = 1'b0; ve[7] = 32'h41700000;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (k < 8) begin din1 = va[k]; din2 = vb[k]; op = vo[k]; dval = 1'b1; end
            else dval = 1'b0;
            @(negedge clk);
            if (k >= 3 && k < 11) begin
                total++;
                if (rdy !== 1'b1 || result !== ve[k-3]) begin
                    bad++;
                    $display("FAIL stream%0d: got rdy=%b res=%h want rdy=1 res=%h", k - 3, rdy, result, ve[k-3]);
                end
            end else begin
                total++; if (rdy !== 1'b0) begin bad++; $display("FAIL stream_idle_c%0d: got rdy=%b want 0", k, rdy); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            rst_n = (k != 2);
            dval  = (k <= 2) || (k == 5);
            din1  = 32'h3F800000; din2 = 32'h40000000; op = 1'b0;
            if (k == 1) din2 = 32'h3F800000;
            @(negedge clk);
            total++;
            if (rdy !== (k == 8)) begin bad++; $display("FAIL midrst_rdy_c%0d: got %b want %b", k, rdy, (k == 8)); end
            if (k == 3 || k == 4) begin
                total++; if (result !== 32'h0) begin bad++; $display("FAIL midrst_result_c%0d: got %h want 00000000", k, result); end
            end
            if (k == 8) begin
                total++; if (result !== 32'h40400000) begin bad++; $display("FAIL midrst_after: got %h want 40400000", result); end
            end
        end
        dval = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round();
        test_special();
        test_back_to_back();
        test_reset_midflight();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
